// File: rtl/uart_rx_auth_if.sv
// Byte-level handshake between the UART receive front end and the
// authentication FSM: serial line in, held byte plus sticky status out.
interface uart_rx_auth_if;
  logic       RX;
  logic       clr_rdy;
  logic       rdy;
  logic [7:0] cmd;
  logic       frm_err;
  logic       ovr_err;

  modport master (
    output RX, clr_rdy,
    input  rdy, cmd, frm_err, ovr_err
  );

  modport slave (
    input  RX, clr_rdy,
    output rdy, cmd, frm_err, ovr_err
  );
endinterface

// File: rtl/uart_rx_auth.sv
// uart_rx_auth: 8N1 UART receiver for the rider-authentication path.
// Synchronises RX, validates the start bit at its mid-point, samples eight
// data bits LSB first and the stop bit, then holds the byte on cmd with a
// sticky rdy flag plus sticky framing-error and overrun flags.
// Optional build macro UART_RX_MAJORITY_EN: every sample point becomes a
// 2-of-3 majority over the last three rx_s values, at unchanged latency.
//
// state | meaning
// IDLE  | waiting for a 1->0 edge on the synchronised line
// START | counting to the start-bit mid-point, rejecting glitches
// DATA  | sampling data bits 0..7 one bit period apart
// STOP  | sampling the stop bit, then publishing the byte or a framing error
module uart_rx_auth #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input logic         clk,
  input logic         rst_n,
  uart_rx_auth_if.slave bus
);

  localparam int unsigned HALF_DIV  = BAUD_DIV / 2;
  localparam logic [15:0] HALF_LOAD = 16'(HALF_DIV - 1);
  localparam logic [15:0] BAUD_LOAD = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [3:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  shift, shift_nxt;
  logic        byte_done, frame_bad;

  logic        rx_meta, rx_s, rx_d1;
  logic [1:0]  sync_fill;
  logic        armed;
  logic        start_edge;
  logic        sample;

  logic        rdy_r, frm_err_r, ovr_err_r;
  logic [7:0]  cmd_r;

`ifdef UART_RX_MAJORITY_EN
  logic        rx_d2;
`endif

  // Synchroniser and sample history. armed only goes high once the
  // synchroniser holds real line data and that data is high, so a line that
  // is low when reset releases (mid-frame) cannot fake a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_d1     <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      rx_d2     <= 1'b1;
`endif
      sync_fill <= 2'd0;
      armed     <= 1'b0;
    end else begin
      rx_meta <= bus.RX;
      rx_s    <= rx_meta;
      rx_d1   <= rx_s;
`ifdef UART_RX_MAJORITY_EN
      rx_d2   <= rx_d1;
`endif
      if (sync_fill != 2'd2)
        sync_fill <= sync_fill + 2'd1;
      if (sync_fill == 2'd2 && rx_s)
        armed <= 1'b1;
    end
  end

  assign start_edge = armed && rx_d1 && !rx_s;

`ifdef UART_RX_MAJORITY_EN
  assign sample = (rx_s & rx_d1) | (rx_s & rx_d2) | (rx_d1 & rx_d2);
`else
  assign sample = rx_s;
`endif

  // FSM state, down-counter, bit counter and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 16'd0;
      bit_cnt <= 4'd0;
      shift   <= 8'h00;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift   <= shift_nxt;
    end
  end

  // Next state: each state counts down to zero, then acts on the sample.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    byte_done   = 1'b0;
    frame_bad   = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) begin
          state_nxt = START;
          cnt_nxt   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt == 16'd0) begin
          if (!sample) begin
            state_nxt   = DATA;
            cnt_nxt     = BAUD_LOAD;
            bit_cnt_nxt = 4'd0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      DATA: begin
        if (cnt == 16'd0) begin
          shift_nxt = {sample, shift[7:1]};
          cnt_nxt   = BAUD_LOAD;
          if (bit_cnt == 4'd7)
            state_nxt = STOP;
          else
            bit_cnt_nxt = bit_cnt + 4'd1;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      STOP: begin
        if (cnt == 16'd0) begin
          state_nxt = IDLE;
          if (sample)
            byte_done = 1'b1;
          else
            frame_bad = 1'b1;
        end else begin
          cnt_nxt = cnt - 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sticky outputs: an ack clears, a completing frame sets and wins over it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_r     <= 1'b0;
      cmd_r     <= 8'h00;
      frm_err_r <= 1'b0;
      ovr_err_r <= 1'b0;
    end else begin
      if (bus.clr_rdy) begin
        rdy_r     <= 1'b0;
        frm_err_r <= 1'b0;
        ovr_err_r <= 1'b0;
      end
      if (byte_done) begin
        cmd_r <= shift;
        rdy_r <= 1'b1;
        if (rdy_r && !bus.clr_rdy)
          ovr_err_r <= 1'b1;
      end
      if (frame_bad)
        frm_err_r <= 1'b1;
    end
  end

  assign bus.rdy     = rdy_r;
  assign bus.cmd     = cmd_r;
  assign bus.frm_err = frm_err_r;
  assign bus.ovr_err = ovr_err_r;

endmodule
